otter_dmem_arbiter: RTL and testbench
=====================================

Name: otter_dmem_arbiter

Overview:
Sequencing controller in front of the two data ports of the superscalar OTTER byte-addressable memory (the port-2 pair driven by issue slots 0 and 1). It accepts one load/store pair per transaction with a valid/ready handshake. Non-conflicting pairs are issued on both ports in the same cycle. Same-word or dual-IO pairs are serialized in program order (slot 0 first). It screens misaligned and out-of-range accesses and returns both results together.

Parameters:
ACTUAL_WIDTH, 14, word-address width of data memory; the valid RAM byte range is 0 .. 2**(ACTUAL_WIDTH+2)-1.
IO_BASE, 32'h11000000, addresses >= IO_BASE are memory-mapped IO.

Ports:
CLK  in  1  system clock; all state updates on posedge.
RST_N  in  1  asynchronous, active-low reset.
REQ_VALID0, REQ_VALID1  in  1  slot request present; slot 0 is older.
REQ_READY  out  1  arbiter can accept a pair this cycle.
REQ_ADDR0, REQ_ADDR1  in  32  byte address.
REQ_DIN0, REQ_DIN1  in  32  store data.
REQ_WE0, REQ_WE1  in  1  1 = store, 0 = load.
REQ_SIZE0, REQ_SIZE1  in  2  0 = byte, 1 = half, 2 = word.
REQ_SIGN0, REQ_SIGN1  in  1  1 = unsigned load.
RSP_VALID  out  1  one-cycle pulse; response fields are valid.
RSP_DATA0, RSP_DATA1  out  32  load data (0 for stores, errors, or absent slots).
RSP_ERR0, RSP_ERR1  out  1  access rejected.
MEM_ADDR2, MEM_ADDR2_2  out  32  memory port 0 / port 1 address.
MEM_DIN2, MEM_DIN2_2  out  32  store data.
MEM_WRITE2, MEM_WRITE2_2  out  1  write strobe.
MEM_READ2, MEM_READ2_2  out  1  read strobe.
MEM_SIZE, MEM_SIZE_2  out  2  access size.
MEM_SIGN, MEM_SIGN_2  out  1  unsigned flag.
MEM_DOUT2, MEM_DOUT2_2  in  32  sliced read data; settles after the negedge within the issue cycle.
IO_IN  in  32  IO read data.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - All MEM_* outputs and RSP_* outputs = 0; REQ_READY = 0 while reset is asserted.
  - Reset mid-transaction abandons it with no response.
- States: IDLE, DUAL, SPLIT_A, SPLIT_B, RESP. All MEM_* outputs are registered.
- IDLE:
  - REQ_READY = 1 only in IDLE.
  - Acceptance: posedge with REQ_READY & (REQ_VALID0 | REQ_VALID1). The arbiter latches both slots plus their valid bits.
- Error check per slot, done at acceptance:
  - Misaligned: size 2 with addr[1:0] != 0; size 1 with addr[1:0] == 3; size 3 always.
  - Out of range: addr >= 2**(ACTUAL_WIDTH+2) and addr < IO_BASE.
  - An errored slot never asserts MEM_READ/MEM_WRITE. RSP_ERR = 1, RSP_DATA = 0.
- Conflict: both slots valid, neither errored, and either
  - addr[ACTUAL_WIDTH+1:2] equal and REQ_WE0 | REQ_WE1, or
  - both addresses >= IO_BASE.
- Transitions:
  - IDLE to DUAL when there is no conflict.
  - IDLE to SPLIT_A when there is a conflict.
  - DUAL to RESP.
  - SPLIT_A to SPLIT_B to RESP.
  - RESP to IDLE.
- DUAL: port 0 carries slot 0 and port 1 carries slot 1, each only if that slot is valid and not errored. Otherwise the port's strobes are 0 and its address is 0.
- SPLIT_A: port 0 carries slot 0; port 1 is idle. At the posedge ending SPLIT_A, the slot-0 result is captured into a hold register.
- SPLIT_B: port 1 carries slot 1; port 0 is idle.
- Read data capture:
  - Slot data is captured at the posedge ending its issue cycle.
  - Source is MEM_DOUT2 / MEM_DOUT2_2, or IO_IN when addr >= IO_BASE.
- RESP:
  - RSP_VALID = 1 for exactly one cycle, with RSP_DATA0/1 and RSP_ERR0/1 registered. Fields hold until the next RESP.
  - MEM_* strobes are 0 in RESP and IDLE.
- Latency from acceptance to RSP_VALID: 2 cycles (non-conflict), 3 cycles (split).
- Throughput: one pair every 3 cycles (non-conflict), every 4 cycles (split).
- A single valid slot is issued as DUAL on its own port; the other slot's response is 0 with no error.
- A slot-0 store followed by a slot-1 load of the same word returns the newly stored value (guaranteed by serialization).

Test Plan:
1. Reset:
   - Stimulus: RST_N low mid-DUAL.
   - Required: all MEM_* strobes 0 immediately; REQ_READY = 1 one posedge after release; no RSP_VALID.
2. Independent loads:
   - Stimulus: lw 0x100 (word 0x11223344) and lw 0x200 (word 0xAABBCCDD).
   - Required: both read strobes in the same cycle; RSP_VALID 2 cycles after accept; DATA0 = 0x11223344, DATA1 = 0xAABBCCDD.
3. Same-word hazard:
   - Stimulus: sw 0xDEADBEEF to 0x100, then lw 0x100.
   - Required: SPLIT_A then SPLIT_B; RSP_VALID at 3 cycles; DATA1 = 0xDEADBEEF.
4. Byte stores to one word:
   - Stimulus: sb 0x55 to 0x101 and sb 0x66 to 0x102.
   - Required: serialized; a later lw 0x100 shows bytes [15:8] = 0x55 and [23:16] = 0x66.
5. Error screening:
   - Stimulus: lw 0x102, and lw 0x00100000 with ACTUAL_WIDTH = 14.
   - Required: no strobes issued; ERR0 = ERR1 = 1; DATA = 0.
6. Dual IO:
   - Stimulus: two loads at 0x11000000 with IO_IN = 0x0000ABCD.
   - Required: serialized; both DATA = 0x0000ABCD. Single slot 1 only: port 0 idle, ERR0 = 0, DATA0 = 0.

Source files
------------

// File: rtl/otter_dmem_arbiter_if.sv
// Bundle of the request, response, memory-port and IO signals around the data-memory arbiter.
// The arbiter uses the slave view; the CPU slots plus memory/IO side use the master view.
interface otter_dmem_arbiter_if;
  logic        REQ_VALID0, REQ_VALID1, REQ_READY;
  logic [31:0] REQ_ADDR0, REQ_ADDR1, REQ_DIN0, REQ_DIN1;
  logic        REQ_WE0, REQ_WE1;
  logic [1:0]  REQ_SIZE0, REQ_SIZE1;
  logic        REQ_SIGN0, REQ_SIGN1;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA0, RSP_DATA1;
  logic        RSP_ERR0, RSP_ERR1;
  logic [31:0] MEM_ADDR2, MEM_ADDR2_2, MEM_DIN2, MEM_DIN2_2;
  logic        MEM_WRITE2, MEM_WRITE2_2, MEM_READ2, MEM_READ2_2;
  logic [1:0]  MEM_SIZE, MEM_SIZE_2;
  logic        MEM_SIGN, MEM_SIGN_2;
  logic [31:0] MEM_DOUT2, MEM_DOUT2_2, IO_IN;

  modport slave (
    input  REQ_VALID0, REQ_VALID1, REQ_ADDR0, REQ_ADDR1, REQ_DIN0, REQ_DIN1,
           REQ_WE0, REQ_WE1, REQ_SIZE0, REQ_SIZE1, REQ_SIGN0, REQ_SIGN1,
           MEM_DOUT2, MEM_DOUT2_2, IO_IN,
    output REQ_READY, RSP_VALID, RSP_DATA0, RSP_DATA1, RSP_ERR0, RSP_ERR1,
           MEM_ADDR2, MEM_ADDR2_2, MEM_DIN2, MEM_DIN2_2, MEM_WRITE2, MEM_WRITE2_2,
           MEM_READ2, MEM_READ2_2, MEM_SIZE, MEM_SIZE_2, MEM_SIGN, MEM_SIGN_2
  );

  modport master (
    output REQ_VALID0, REQ_VALID1, REQ_ADDR0, REQ_ADDR1, REQ_DIN0, REQ_DIN1,
           REQ_WE0, REQ_WE1, REQ_SIZE0, REQ_SIZE1, REQ_SIGN0, REQ_SIGN1,
           MEM_DOUT2, MEM_DOUT2_2, IO_IN,
    input  REQ_READY, RSP_VALID, RSP_DATA0, RSP_DATA1, RSP_ERR0, RSP_ERR1,
           MEM_ADDR2, MEM_ADDR2_2, MEM_DIN2, MEM_DIN2_2, MEM_WRITE2, MEM_WRITE2_2,
           MEM_READ2, MEM_READ2_2, MEM_SIZE, MEM_SIZE_2, MEM_SIGN, MEM_SIGN_2
  );
endinterface

// File: rtl/otter_dmem_arbiter.sv
// Pairs slot-0/slot-1 load/store requests onto the two OTTER data-memory ports, issuing
// independent pairs together and serializing same-word-with-store or dual-IO pairs.
module otter_dmem_arbiter #(
  parameter int unsigned ACTUAL_WIDTH = 14,
  parameter logic [31:0] IO_BASE      = 32'h11000000
) (
  input logic                  CLK,
  input logic                  RST_N,
  otter_dmem_arbiter_if.slave  bus
);

  localparam logic [32:0] RamBytes = 33'd1 << (ACTUAL_WIDTH + 2);

  typedef enum logic [2:0] {StIdle, StDual, StSplitA, StSplitB, StResp} state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [1:0]  size;
    logic        sign;
  } slot_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sign;
  } port_t;

  function automatic logic f_err(logic [31:0] addr, logic [1:0] size);
    logic mis, oor;
    mis = (size == 2'd3) || (size == 2'd2 && addr[1:0] != 2'd0) ||
          (size == 2'd1 && addr[1:0] == 2'd3);
    oor = ({1'b0, addr} >= RamBytes) && (addr < IO_BASE);
    return mis || oor;
  endfunction

  function automatic port_t f_issue(slot_t s);
    port_t p;
    p = '0;
    if (s.valid && !s.err) begin
      p.addr = s.addr;
      p.din  = s.din;
      p.we   = s.we;
      p.re   = !s.we;
      p.size = s.size;
      p.sign = s.sign;
    end
    return p;
  endfunction

  // Loads only; stores, errored and absent slots report zero.
  function automatic logic [31:0] f_rdata(slot_t s, logic [31:0] dout, logic [31:0] io);
    if (s.valid && !s.err && !s.we) return (s.addr >= IO_BASE) ? io : dout;
    return 32'h0;
  endfunction

  state_e      r_state, w_state_d;
  slot_t       r_slot0, r_slot1, w_slot0_d, w_slot1_d, w_in0, w_in1;
  port_t       r_port0, r_port1, w_port0_d, w_port1_d;
  logic [31:0] r_hold0, w_hold0_d;
  logic        r_ready, w_ready_d;
  logic        r_rsp_valid, w_rsp_valid_d;
  logic [31:0] r_rsp_data0, r_rsp_data1, w_rsp_data0_d, w_rsp_data1_d;
  logic        r_rsp_err0, r_rsp_err1, w_rsp_err0_d, w_rsp_err1_d;
  logic        w_conflict;

  always_comb begin
    w_in0 = '{valid: bus.REQ_VALID0, err: bus.REQ_VALID0 && f_err(bus.REQ_ADDR0, bus.REQ_SIZE0),
              addr: bus.REQ_ADDR0, din: bus.REQ_DIN0, we: bus.REQ_WE0,
              size: bus.REQ_SIZE0, sign: bus.REQ_SIGN0};
    w_in1 = '{valid: bus.REQ_VALID1, err: bus.REQ_VALID1 && f_err(bus.REQ_ADDR1, bus.REQ_SIZE1),
              addr: bus.REQ_ADDR1, din: bus.REQ_DIN1, we: bus.REQ_WE1,
              size: bus.REQ_SIZE1, sign: bus.REQ_SIGN1};
    w_conflict = w_in0.valid && w_in1.valid && !w_in0.err && !w_in1.err &&
                 (((w_in0.addr[ACTUAL_WIDTH+1:2] == w_in1.addr[ACTUAL_WIDTH+1:2]) &&
                   (w_in0.we || w_in1.we)) ||
                  ((w_in0.addr >= IO_BASE) && (w_in1.addr >= IO_BASE)));
  end

  always_comb begin
    w_state_d     = r_state;
    w_slot0_d     = r_slot0;
    w_slot1_d     = r_slot1;
    w_port0_d     = '0;
    w_port1_d     = '0;
    w_hold0_d     = r_hold0;
    w_rsp_valid_d = 1'b0;
    w_rsp_data0_d = r_rsp_data0;
    w_rsp_data1_d = r_rsp_data1;
    w_rsp_err0_d  = r_rsp_err0;
    w_rsp_err1_d  = r_rsp_err1;
    case (r_state)
      StIdle: begin
        if (r_ready && (bus.REQ_VALID0 || bus.REQ_VALID1)) begin
          w_slot0_d = w_in0;
          w_slot1_d = w_in1;
          w_port0_d = f_issue(w_in0);
          if (w_conflict) begin
            w_state_d = StSplitA;
          end else begin
            w_state_d = StDual;
            w_port1_d = f_issue(w_in1);
          end
        end
      end
      StDual: begin
        w_state_d     = StResp;
        w_rsp_valid_d = 1'b1;
        w_rsp_data0_d = f_rdata(r_slot0, bus.MEM_DOUT2, bus.IO_IN);
        w_rsp_data1_d = f_rdata(r_slot1, bus.MEM_DOUT2_2, bus.IO_IN);
        w_rsp_err0_d  = r_slot0.err;
        w_rsp_err1_d  = r_slot1.err;
      end
      StSplitA: begin
        w_state_d = StSplitB;
        w_hold0_d = f_rdata(r_slot0, bus.MEM_DOUT2, bus.IO_IN);
        w_port1_d = f_issue(r_slot1);
      end
      StSplitB: begin
        w_state_d     = StResp;
        w_rsp_valid_d = 1'b1;
        w_rsp_data0_d = r_hold0;
        w_rsp_data1_d = f_rdata(r_slot1, bus.MEM_DOUT2_2, bus.IO_IN);
        w_rsp_err0_d  = r_slot0.err;
        w_rsp_err1_d  = r_slot1.err;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Registered so READY stays low throughout reset and rises one edge after release.
    w_ready_d = (w_state_d == StIdle);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= StIdle;
      r_slot0     <= '0;
      r_slot1     <= '0;
      r_port0     <= '0;
      r_port1     <= '0;
      r_hold0     <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data0 <= '0;
      r_rsp_data1 <= '0;
      r_rsp_err0  <= 1'b0;
      r_rsp_err1  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_slot0     <= w_slot0_d;
      r_slot1     <= w_slot1_d;
      r_port0     <= w_port0_d;
      r_port1     <= w_port1_d;
      r_hold0     <= w_hold0_d;
      r_ready     <= w_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data0 <= w_rsp_data0_d;
      r_rsp_data1 <= w_rsp_data1_d;
      r_rsp_err0  <= w_rsp_err0_d;
      r_rsp_err1  <= w_rsp_err1_d;
    end
  end

  assign bus.REQ_READY    = r_ready;
  assign bus.RSP_VALID    = r_rsp_valid;
  assign bus.RSP_DATA0    = r_rsp_data0;
  assign bus.RSP_DATA1    = r_rsp_data1;
  assign bus.RSP_ERR0     = r_rsp_err0;
  assign bus.RSP_ERR1     = r_rsp_err1;
  assign bus.MEM_ADDR2    = r_port0.addr;
  assign bus.MEM_DIN2     = r_port0.din;
  assign bus.MEM_WRITE2   = r_port0.we;
  assign bus.MEM_READ2    = r_port0.re;
  assign bus.MEM_SIZE     = r_port0.size;
  assign bus.MEM_SIGN     = r_port0.sign;
  assign bus.MEM_ADDR2_2  = r_port1.addr;
  assign bus.MEM_DIN2_2   = r_port1.din;
  assign bus.MEM_WRITE2_2 = r_port1.we;
  assign bus.MEM_READ2_2  = r_port1.re;
  assign bus.MEM_SIZE_2   = r_port1.size;
  assign bus.MEM_SIGN_2   = r_port1.sign;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Directed bench for otter_dmem_arbiter with a small byte-addressable memory behind both ports.
module tb_otter_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  otter_dmem_arbiter_if bus ();

  otter_dmem_arbiter #(
    .ACTUAL_WIDTH (14),
    .IO_BASE      (32'h11000000)
  ) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [1:0]  size;
    logic        sign;
  } req_t;

  // Memory model: aliased on addr[11:2], writes at posedge, sliced read data after negedge.
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] mem_rd(logic [31:0] a, logic [1:0] sz, logic uns);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[a[11:2]];
    b = w[8*a[1:0] +: 8];
    h = (a[1:0] == 2'd3) ? 16'h0 : w[8*a[1:0] +: 16];
    case (sz)
      2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  task automatic mem_wr(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    case (sz)
      2'd0:    mem[a[11:2]][8*a[1:0] +: 8] = d[7:0];
      2'd1:    if (a[1:0] != 2'd3) mem[a[11:2]][8*a[1:0] +: 16] = d[15:0];
      default: mem[a[11:2]] = d;
    endcase
  endtask

  always @(posedge clk) begin
    if (bus.MEM_WRITE2 === 1'b1) mem_wr(bus.MEM_ADDR2, bus.MEM_DIN2, bus.MEM_SIZE);
    if (bus.MEM_WRITE2_2 === 1'b1) mem_wr(bus.MEM_ADDR2_2, bus.MEM_DIN2_2, bus.MEM_SIZE_2);
  end

  always @(negedge clk) begin
    bus.MEM_DOUT2   <= (bus.MEM_READ2 === 1'b1) ?
                       mem_rd(bus.MEM_ADDR2, bus.MEM_SIZE, bus.MEM_SIGN) : 32'h0;
    bus.MEM_DOUT2_2 <= (bus.MEM_READ2_2 === 1'b1) ?
                       mem_rd(bus.MEM_ADDR2_2, bus.MEM_SIZE_2, bus.MEM_SIGN_2) : 32'h0;
  end

  task automatic drive(input req_t r0, input req_t r1);
    bus.REQ_VALID0 = r0.v;
    bus.REQ_ADDR0  = r0.addr;
    bus.REQ_DIN0   = r0.din;
    bus.REQ_WE0    = r0.we;
    bus.REQ_SIZE0  = r0.size;
    bus.REQ_SIGN0  = r0.sign;
    bus.REQ_VALID1 = r1.v;
    bus.REQ_ADDR1  = r1.addr;
    bus.REQ_DIN1   = r1.din;
    bus.REQ_WE1    = r1.we;
    bus.REQ_SIZE1  = r1.size;
    bus.REQ_SIGN1  = r1.sign;
  endtask

  function automatic req_t mk(logic v, logic [31:0] a, logic [31:0] d, logic we,
                              logic [1:0] sz, logic uns);
    req_t r;
    r.v = v; r.addr = a; r.din = d; r.we = we; r.size = sz; r.sign = uns;
    return r;
  endfunction

  // Runs one pair; lat counts posedges from the accepting edge until RSP_VALID is seen,
  // is0/is1 bit k = port strobe in the k-th cycle after acceptance.
  task automatic run_pair(input req_t r0, input req_t r1, output int lat,
                          output logic [7:0] is0, output logic [7:0] is1,
                          output logic [31:0] ma0, output logic [31:0] ma1,
                          output logic [31:0] d0, output logic [31:0] d1,
                          output logic e0, output logic e1);
    int w;
    w   = 0;
    lat = 99;
    is0 = '0;
    is1 = '0;
    while (bus.REQ_READY !== 1'b1 && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    drive(r0, r1);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0));
    ma0 = bus.MEM_ADDR2;
    ma1 = bus.MEM_ADDR2_2;
    for (int c = 0; c < 8; c++) begin
      is0[c] = bus.MEM_READ2 | bus.MEM_WRITE2;
      is1[c] = bus.MEM_READ2_2 | bus.MEM_WRITE2_2;
      if (bus.RSP_VALID === 1'b1) begin
        lat = c + 1;
        break;
      end
      @(posedge clk); #1;
    end
    d0 = bus.RSP_DATA0;
    d1 = bus.RSP_DATA1;
    e0 = bus.RSP_ERR0;
    e1 = bus.RSP_ERR1;
  endtask

  int          lat;
  logic [7:0]  is0, is1;
  logic [31:0] ma0, ma1, d0, d1;
  logic        e0, e1;

  task automatic test_reset();
    int seen;
    n_cmp++; if (bus.REQ_READY !== 1'b0) begin n_bad++;
      $display("FAIL rst_ready got %b want 0", bus.REQ_READY); end
    n_cmp++; if ({bus.MEM_READ2, bus.MEM_WRITE2, bus.MEM_READ2_2, bus.MEM_WRITE2_2,
                  bus.RSP_VALID} !== 5'b0) begin n_bad++;
      $display("FAIL rst_strobes got nonzero want 0"); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready_release got %b want 1", bus.REQ_READY); end
    drive(mk(1, 32'h100, 0, 0, 2, 0), mk(1, 32'h200, 0, 0, 2, 0));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0));
    n_cmp++; if ({bus.MEM_READ2, bus.MEM_READ2_2, bus.REQ_READY} !== 3'b110) begin n_bad++;
      $display("FAIL rst_dual_issue got %b want 110",
               {bus.MEM_READ2, bus.MEM_READ2_2, bus.REQ_READY}); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.MEM_READ2, bus.MEM_READ2_2, bus.MEM_ADDR2} !== 34'h0) begin n_bad++;
      $display("FAIL rst_async_clear got %h want 0",
               {bus.MEM_READ2, bus.MEM_READ2_2, bus.MEM_ADDR2}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (bus.REQ_READY !== 1'b0) begin n_bad++;
      $display("FAIL rst_ready_held got %b want 0", bus.REQ_READY); end
    rst_n = 1'b1;
    seen  = 0;
    @(posedge clk); #1;
    n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready_again got %b want 1", bus.REQ_READY); end
    for (int c = 0; c < 4; c++) begin
      if (bus.RSP_VALID !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_bad++;
      $display("FAIL rst_no_resp got %0d pulses want 0", seen); end
  endtask

  task automatic test_indep_loads();
    run_pair(mk(1, 32'h100, 0, 0, 2, 0), mk(1, 32'h200, 0, 0, 2, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL indep_lat got %0d want 2", lat); end
    n_cmp++; if ({is0, is1} !== {8'h01, 8'h01}) begin n_bad++;
      $display("FAIL indep_issue got %h/%h want 01/01", is0, is1); end
    n_cmp++; if ({ma0, ma1} !== {32'h100, 32'h200}) begin n_bad++;
      $display("FAIL indep_addr got %h/%h want 100/200", ma0, ma1); end
    n_cmp++; if ({d0, d1, e0, e1} !== {32'h11223344, 32'hAABBCCDD, 2'b00}) begin n_bad++;
      $display("FAIL indep_data got %h %h err %b%b want 11223344 aabbccdd err 00",
               d0, d1, e0, e1); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.RSP_VALID, bus.REQ_READY, bus.RSP_DATA0} !== {2'b01, 32'h11223344})
    begin n_bad++;
      $display("FAIL indep_pulse_hold got v%b r%b %h want v0 r1 11223344",
               bus.RSP_VALID, bus.REQ_READY, bus.RSP_DATA0); end
  endtask

  task automatic test_same_word();
    run_pair(mk(1, 32'h100, 32'hDEADBEEF, 1, 2, 0), mk(1, 32'h100, 0, 0, 2, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL hazard_lat got %0d want 3", lat); end
    n_cmp++; if ({is0, is1} !== {8'h01, 8'h02}) begin n_bad++;
      $display("FAIL hazard_issue got %h/%h want 01/02", is0, is1); end
    n_cmp++; if ({d0, d1, e0, e1} !== {32'h0, 32'hDEADBEEF, 2'b00}) begin n_bad++;
      $display("FAIL hazard_data got %h %h err %b%b want 0 deadbeef err 00",
               d0, d1, e0, e1); end
  endtask

  task automatic test_byte_stores();
    run_pair(mk(1, 32'h101, 32'h55, 1, 0, 0), mk(1, 32'h102, 32'h66, 1, 0, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({lat, is0, is1} !== {32'd3, 8'h01, 8'h02}) begin n_bad++;
      $display("FAIL sb_serial got lat %0d %h/%h want 3 01/02", lat, is0, is1); end
    run_pair(mk(1, 32'h100, 0, 0, 2, 0), mk(0, 0, 0, 0, 0, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({lat, is0, is1} !== {32'd2, 8'h01, 8'h00}) begin n_bad++;
      $display("FAIL sb_readback_issue got lat %0d %h/%h want 2 01/00", lat, is0, is1); end
    n_cmp++; if ({d0, d1, e0, e1} !== {32'hDE6655EF, 32'h0, 2'b00}) begin n_bad++;
      $display("FAIL sb_readback got %h %h want de6655ef 0", d0, d1); end
    // Same word, loads only: no hazard, signed vs unsigned halves.
    run_pair(mk(1, 32'h102, 0, 0, 1, 0), mk(1, 32'h102, 0, 0, 1, 1),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({lat, is0, is1} !== {32'd2, 8'h01, 8'h01}) begin n_bad++;
      $display("FAIL lh_dual got lat %0d %h/%h want 2 01/01", lat, is0, is1); end
    n_cmp++; if ({d0, d1} !== {32'hFFFFDE66, 32'h0000DE66}) begin n_bad++;
      $display("FAIL lh_data got %h %h want ffffde66 0000de66", d0, d1); end
  endtask

  task automatic test_errors();
    run_pair(mk(1, 32'h102, 0, 0, 2, 0), mk(1, 32'h00100000, 0, 0, 2, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({lat, is0, is1} !== {32'd2, 8'h00, 8'h00}) begin n_bad++;
      $display("FAIL err_issue got lat %0d %h/%h want 2 00/00", lat, is0, is1); end
    n_cmp++; if ({d0, d1, e0, e1} !== {64'h0, 2'b11}) begin n_bad++;
      $display("FAIL err_rsp got %h %h err %b%b want 0 0 err 11", d0, d1, e0, e1); end
    run_pair(mk(1, 32'h0000FFFC, 0, 0, 2, 0), mk(1, 32'h00010000, 0, 0, 1, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({is0, is1, e0, e1} !== {8'h01, 8'h00, 2'b01}) begin n_bad++;
      $display("FAIL err_edge got %h/%h err %b%b want 01/00 err 01", is0, is1, e0, e1); end
    n_cmp++; if ({d0, d1} !== {32'hCAFEF00D, 32'h0}) begin n_bad++;
      $display("FAIL err_edge_data got %h %h want cafef00d 0", d0, d1); end
    run_pair(mk(1, 32'h100, 0, 0, 3, 0), mk(1, 32'h103, 0, 0, 1, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({is0, is1, e0, e1} !== {8'h00, 8'h00, 2'b11}) begin n_bad++;
      $display("FAIL err_size got %h/%h err %b%b want 00/00 err 11", is0, is1, e0, e1); end
  endtask

  task automatic test_dual_io();
    bus.IO_IN = 32'h0000ABCD;
    run_pair(mk(1, 32'h11000000, 0, 0, 2, 0), mk(1, 32'h11000000, 0, 0, 2, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({lat, is0, is1} !== {32'd3, 8'h01, 8'h02}) begin n_bad++;
      $display("FAIL io_serial got lat %0d %h/%h want 3 01/02", lat, is0, is1); end
    n_cmp++; if ({d0, d1} !== {32'h0000ABCD, 32'h0000ABCD}) begin n_bad++;
      $display("FAIL io_data got %h %h want 0000abcd 0000abcd", d0, d1); end
    run_pair(mk(0, 0, 0, 0, 0, 0), mk(1, 32'h200, 0, 0, 2, 0),
             lat, is0, is1, ma0, ma1, d0, d1, e0, e1);
    n_cmp++; if ({lat, is0, is1, ma0} !== {32'd2, 8'h00, 8'h01, 32'h0}) begin n_bad++;
      $display("FAIL slot1_only_issue got lat %0d %h/%h a0 %h want 2 00/01 a0 0",
               lat, is0, is1, ma0); end
    n_cmp++; if ({d0, d1, e0, e1} !== {32'h0, 32'hAABBCCDD, 2'b00}) begin n_bad++;
      $display("FAIL slot1_only_data got %h %h err %b%b want 0 aabbccdd err 00",
               d0, d1, e0, e1); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]     = 32'h0BADBAD0;
    mem[32'h40] = 32'h11223344;
    mem[32'h80] = 32'hAABBCCDD;
    mem[1023]  = 32'hCAFEF00D;
    bus.IO_IN  = 32'h0;
    drive(mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_reset();
    test_indep_loads();
    test_same_word();
    test_byte_stores();
    test_errors();
    test_dual_io();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
